// File: rtl/cmd_issue_queue_pkg.sv
// Shared definitions for the DDR3 host command issue queue: command field
// layout, the packed command view and the read-address tag extraction.
package cmd_issue_queue_pkg;

  localparam int CMD_W      = 34;
  localparam int ADDR_TAG_W = 28;

  localparam int RANK_MSB     = 33;
  localparam int RANK_LSB     = 32;
  localparam int RW_BIT       = 31;
  localparam int ROW_MSB      = 29;
  localparam int ROW_LSB      = 17;
  localparam int BL_BIT       = 15;
  localparam int AUTO_PRE_BIT = 13;
  localparam int COL_MSB      = 12;
  localparam int COL_LSB      = 3;
  localparam int BANK_MSB     = 2;
  localparam int BANK_LSB     = 0;

  typedef enum logic {
    RW_WRITE = 1'b0,
    RW_READ  = 1'b1
  } rw_e;

  typedef struct packed {
    logic [1:0]  rank;
    rw_e         rw;
    logic        rsvd30;
    logic [12:0] row;
    logic        rsvd16;
    logic        bl;
    logic        rsvd14;
    logic        auto_pre;
    logic [9:0]  col;
    logic [2:0]  bank;
  } cmd_t;

  // Tag carried with each outstanding read: {rank, bank, row, col}.
  function automatic logic [ADDR_TAG_W-1:0] addr_tag(input logic [CMD_W-1:0] c);
    return {c[RANK_MSB:RANK_LSB], c[BANK_MSB:BANK_LSB],
            c[ROW_MSB:ROW_LSB],   c[COL_MSB:COL_LSB]};
  endfunction

endpackage

// File: rtl/cmd_issue_queue_sync_fifo.sv
// Single-clock FIFO with a combinational head view. Pushes while full and
// pops while empty are ignored; DEPTH must be a power of 2.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [PTR_W:0]   count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // NOTE: non-blocking (<=) for all clocked state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage has no reset; pointers and count alone define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/cmd_issue_queue.sv
// Host-side front end for the DDR3 controller command port: buffers commands
// with write data, issues in order when the target bank is ready, and tags reads.
module cmd_issue_queue
  import cmd_issue_queue_pkg::*;
#(
  parameter int DATA_W    = 128,
  parameter int CMD_DEPTH = 8,
  parameter int RD_DEPTH  = 16
) (
  input  logic                         clk,
  input  logic                         power_on_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CMD_W-1:0]             in_command,
  input  logic [DATA_W-1:0]            in_wdata,
  output logic [CMD_W-1:0]             command,
  output logic                         valid,
  output logic [DATA_W-1:0]            write_data,
  input  logic [7:0]                   ba_cmd_pm,
  input  logic [DATA_W-1:0]            read_data,
  input  logic                         read_data_valid,
  output logic                         rsp_valid,
  output logic [DATA_W-1:0]            rsp_data,
  output logic [ADDR_TAG_W-1:0]        rsp_addr,
  output logic                         rsp_underflow,
  output logic [$clog2(CMD_DEPTH):0]   level
);

  localparam int ENT_W = CMD_W + DATA_W;

  logic [ENT_W-1:0]             head_ent;
  logic [CMD_W-1:0]             head_bits;
  logic [DATA_W-1:0]            head_wdata;
  cmd_t                         head_cmd;
  logic                         cmd_full;
  logic                         cmd_empty;
  logic                         issue;
  logic                         tag_push;
  logic                         tag_full;
  logic                         tag_empty;
  logic                         rsp_hit;
  logic [ADDR_TAG_W-1:0]        tag_head;
  logic [$clog2(RD_DEPTH):0]    tag_count_unused;

  assign {head_bits, head_wdata} = head_ent;
  assign head_cmd = cmd_t'(head_bits);
  assign in_ready = !cmd_full;

  sync_fifo #(
    .WIDTH (ENT_W),
    .DEPTH (CMD_DEPTH)
  ) u_cmd_q (
    .clk   (clk),
    .rst_n (power_on_rst_n),
    .push  (in_valid && in_ready),
    .wdata ({in_command, in_wdata}),
    .pop   (issue),
    .rdata (head_ent),
    .full  (cmd_full),
    .empty (cmd_empty),
    .count (level)
  );

  // A read may only leave when there is room to remember where its data goes.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    issue = 1'b0;
    if (!cmd_empty && ba_cmd_pm[head_cmd.bank]) begin
      issue = (head_cmd.rw == RW_WRITE) || !tag_full;
    end
  end

  assign tag_push = issue && (head_cmd.rw == RW_READ);
  assign rsp_hit  = read_data_valid && !tag_empty;

  sync_fifo #(
    .WIDTH (ADDR_TAG_W),
    .DEPTH (RD_DEPTH)
  ) u_tag_q (
    .clk   (clk),
    .rst_n (power_on_rst_n),
    .push  (tag_push),
    .wdata (addr_tag(head_bits)),
    .pop   (rsp_hit),
    .rdata (tag_head),
    .full  (tag_full),
    .empty (tag_empty),
    .count (tag_count_unused)
  );

  always_ff @(posedge clk or negedge power_on_rst_n) begin
    if (!power_on_rst_n) begin
      command       <= '0;
      valid         <= 1'b0;
      write_data    <= '0;
      rsp_valid     <= 1'b0;
      rsp_data      <= '0;
      rsp_addr      <= '0;
      rsp_underflow <= 1'b0;
    end else begin
      valid         <= issue;
      command       <= issue ? head_bits : '0;
      write_data    <= (issue && head_cmd.rw == RW_WRITE) ? head_wdata : '0;
      rsp_valid     <= rsp_hit;
      rsp_data      <= rsp_hit ? read_data : '0;
      rsp_addr      <= rsp_hit ? tag_head : '0;
      if (read_data_valid && tag_empty) rsp_underflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cmd_issue_queue.sv
// Self-checking bench for cmd_issue_queue: directed scenarios plus randomized
// traffic checked against a queue-based reference model.
module tb_cmd_issue_queue;

  localparam int DATA_W    = 128;
  localparam int CMD_DEPTH = 8;
  localparam int RD_DEPTH  = 16;

  logic                 clk = 1'b0;
  logic                 power_on_rst_n;
  logic                 in_valid;
  logic                 in_ready;
  logic [33:0]          in_command;
  logic [DATA_W-1:0]    in_wdata;
  logic [33:0]          command;
  logic                 valid;
  logic [DATA_W-1:0]    write_data;
  logic [7:0]           ba_cmd_pm;
  logic [DATA_W-1:0]    read_data;
  logic                 read_data_valid;
  logic                 rsp_valid;
  logic [DATA_W-1:0]    rsp_data;
  logic [27:0]          rsp_addr;
  logic                 rsp_underflow;
  logic [3:0]           level;

  always #5 clk = ~clk;

  cmd_issue_queue #(
    .DATA_W    (DATA_W),
    .CMD_DEPTH (CMD_DEPTH),
    .RD_DEPTH  (RD_DEPTH)
  ) dut (
    .clk             (clk),
    .power_on_rst_n  (power_on_rst_n),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_command      (in_command),
    .in_wdata        (in_wdata),
    .command         (command),
    .valid           (valid),
    .write_data      (write_data),
    .ba_cmd_pm       (ba_cmd_pm),
    .read_data       (read_data),
    .read_data_valid (read_data_valid),
    .rsp_valid       (rsp_valid),
    .rsp_data        (rsp_data),
    .rsp_addr        (rsp_addr),
    .rsp_underflow   (rsp_underflow),
    .level           (level)
  );

  // Reference model: pending commands and outstanding read addresses as queues.
  typedef struct {
    logic [33:0]       cmd;
    logic [DATA_W-1:0] wd;
  } ent_t;

  ent_t        mq[$];
  logic [27:0] tq[$];
  bit          m_under;

  logic              e_valid;
  logic [33:0]       e_command;
  logic [DATA_W-1:0] e_wdata;
  logic              e_rsp_valid;
  logic [DATA_W-1:0] e_rsp_data;
  logic [27:0]       e_rsp_addr;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [33:0] mk(input int rank, input int rw, input int row,
                                     input int col, input int bank);
    logic [33:0] c = '0;
    c[33:32] = rank[1:0];
    c[31]    = rw[0];
    c[29:17] = row[12:0];
    c[12:3]  = col[9:0];
    c[2:0]   = bank[2:0];
    return c;
  endfunction

  function automatic logic [27:0] tag_of(input logic [33:0] c);
    return {c[33:32], c[2:0], c[29:17], c[12:3]};
  endfunction

  function automatic logic [DATA_W-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Advance DUT and model by one clock; expected outputs land in e_* and model state.
  task automatic tick();
    bit   acc;
    bit   iss;
    ent_t h;
    acc = in_valid && (mq.size() < CMD_DEPTH);
    iss = 1'b0;
    if (mq.size() > 0) begin
      h   = mq[0];
      iss = ba_cmd_pm[h.cmd[2:0]] && (!h.cmd[31] || tq.size() < RD_DEPTH);
    end
    e_rsp_valid = 1'b0;
    e_rsp_data  = '0;
    e_rsp_addr  = '0;
    if (read_data_valid) begin
      if (tq.size() > 0) begin
        e_rsp_valid = 1'b1;
        e_rsp_data  = read_data;
        e_rsp_addr  = tq.pop_front();
      end else begin
        m_under = 1'b1;
      end
    end
    e_valid   = iss;
    e_command = iss ? h.cmd : '0;
    e_wdata   = (iss && !h.cmd[31]) ? h.wd : '0;
    if (iss) begin
      mq.delete(0);
      if (h.cmd[31]) tq.push_back(tag_of(h.cmd));
    end
    if (acc) mq.push_back('{cmd: in_command, wd: in_wdata});
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_valid        = 1'b0;
    in_command      = '0;
    in_wdata        = '0;
    read_data_valid = 1'b0;
    read_data       = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    ba_cmd_pm      = '0;
    power_on_rst_n = 1'b0;
    mq.delete();
    tq.delete();
    m_under = 1'b0;
    @(posedge clk);
    #1;
    power_on_rst_n = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    ba_cmd_pm      = '0;
    power_on_rst_n = 1'b0;
    mq.delete();
    tq.delete();
    m_under = 1'b0;
    #3;
    n_vec++;
    if ({valid, command, write_data, rsp_valid, rsp_data, rsp_addr, rsp_underflow} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: got valid=%0b cmd=%h rsp_valid=%0b uflow=%0b, want all 0",
               valid, command, rsp_valid, rsp_underflow);
    end
    n_vec++;
    if (in_ready !== 1'b1 || level !== 4'd0) begin
      n_err++;
      $display("FAIL reset_ready_level: got in_ready=%0b level=%0d, want 1 and 0", in_ready, level);
    end
    @(posedge clk);
    #1;
    power_on_rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    logic [33:0]       c;
    logic [DATA_W-1:0] d;
    c = mk(0, 0, 5, 8, 0);
    d = 128'h0123456789ABCDEF0123456789ABCDEF;
    ba_cmd_pm  = 8'h01;
    in_valid   = 1'b1;
    in_command = c;
    in_wdata   = d;
    tick();
    idle_inputs();
    n_vec++;
    if (valid !== 1'b0 || level !== 4'd1) begin
      n_err++;
      $display("FAIL wr_accept: got valid=%0b level=%0d, want 0 and 1", valid, level);
    end
    tick();
    n_vec++;
    if (valid !== 1'b1 || command !== c || write_data !== d) begin
      n_err++;
      $display("FAIL wr_issue: got valid=%0b cmd=%h data=%h, want 1 %h %h",
               valid, command, write_data, c, d);
    end
    tick();
    n_vec++;
    if (valid !== 1'b0 || command !== '0 || write_data !== '0) begin
      n_err++;
      $display("FAIL wr_idle: got valid=%0b cmd=%h data=%h, want all 0", valid, command, write_data);
    end
  endtask

  task automatic test_bank_block();
    logic [33:0]       c;
    logic [DATA_W-1:0] d;
    c = mk(1, 1, 7, 4, 2);
    ba_cmd_pm  = 8'hFB;
    in_valid   = 1'b1;
    in_command = c;
    tick();
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      tick();
      n_vec++;
      if (valid !== 1'b0 || level !== 4'd1) begin
        n_err++;
        $display("FAIL blk_stall[%0d]: got valid=%0b level=%0d, want 0 and 1", i, valid, level);
      end
    end
    ba_cmd_pm = 8'hFF;
    tick();
    n_vec++;
    if (valid !== 1'b1 || command !== c || write_data !== '0 || level !== 4'd0) begin
      n_err++;
      $display("FAIL blk_issue: got valid=%0b cmd=%h data=%h level=%0d, want 1 %h 0 0",
               valid, command, write_data, level, c);
    end
    d = rnd_data();
    read_data_valid = 1'b1;
    read_data       = d;
    tick();
    idle_inputs();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_addr !== tag_of(c) || rsp_data !== d) begin
      n_err++;
      $display("FAIL blk_return: got rsp_valid=%0b addr=%h, want 1 %h", rsp_valid, rsp_addr, tag_of(c));
    end
  endtask

  task automatic test_full();
    logic [33:0]       cs[8];
    logic [DATA_W-1:0] ds[8];
    ba_cmd_pm = 8'h00;
    for (int i = 0; i < 8; i++) begin
      cs[i] = mk($urandom_range(0, 3), 0, $urandom_range(0, 8191), $urandom_range(0, 1023), i);
      ds[i] = rnd_data();
      in_valid   = 1'b1;
      in_command = cs[i];
      in_wdata   = ds[i];
      tick();
      n_vec++;
      if (level !== 4'(i + 1)) begin
        n_err++;
        $display("FAIL full_fill[%0d]: got level=%0d, want %0d", i, level, i + 1);
      end
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL full_ready: got in_ready=%0b, want 0", in_ready);
    end
    in_command = mk(3, 0, 99, 99, 1);
    in_wdata   = rnd_data();
    tick();
    n_vec++;
    if (level !== 4'd8) begin
      n_err++;
      $display("FAIL full_reject: got level=%0d, want 8", level);
    end
    idle_inputs();
    ba_cmd_pm = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      tick();
      n_vec++;
      if (valid !== 1'b1 || command !== cs[i] || write_data !== ds[i]) begin
        n_err++;
        $display("FAIL full_drain[%0d]: got valid=%0b cmd=%h, want 1 %h", i, valid, command, cs[i]);
      end
    end
    tick();
    n_vec++;
    if (valid !== 1'b0 || level !== 4'd0) begin
      n_err++;
      $display("FAIL full_empty: got valid=%0b level=%0d, want 0 0", valid, level);
    end
  endtask

  task automatic test_reads_in_order();
    logic [DATA_W-1:0] d[3];
    ba_cmd_pm = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      in_valid   = 1'b1;
      in_command = mk(0, 1, i + 1, 0, 3);
      tick();
    end
    idle_inputs();
    tick();
    tick();
    for (int i = 0; i < 3; i++) d[i] = rnd_data();
    for (int i = 0; i < 3; i++) begin
      read_data_valid = 1'b1;
      read_data       = d[i];
      tick();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_data !== d[i] || rsp_addr !== tag_of(mk(0, 1, i + 1, 0, 3))
          || rsp_underflow !== 1'b0) begin
        n_err++;
        $display("FAIL rd_order[%0d]: got valid=%0b addr=%h uflow=%0b, want 1 %h 0",
                 i, rsp_valid, rsp_addr, rsp_underflow, tag_of(mk(0, 1, i + 1, 0, 3)));
      end
    end
    idle_inputs();
    tick();
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_underflow !== 1'b0) begin
      n_err++;
      $display("FAIL rd_after: got rsp_valid=%0b uflow=%0b, want 0 0", rsp_valid, rsp_underflow);
    end
  endtask

  task automatic test_tag_full();
    ba_cmd_pm = 8'hFF;
    for (int i = 0; i < 17; i++) begin
      in_valid   = 1'b1;
      in_command = mk(2, 1, i, i, i % 8);
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_vec++;
      if (valid !== 1'b0 || level !== 4'd1) begin
        n_err++;
        $display("FAIL tag_stall[%0d]: got valid=%0b level=%0d, want 0 1", i, valid, level);
      end
    end
    read_data_valid = 1'b1;
    read_data       = rnd_data();
    tick();
    n_vec++;
    if (rsp_valid !== 1'b1 || rsp_addr !== tag_of(mk(2, 1, 0, 0, 0)) || valid !== 1'b0) begin
      n_err++;
      $display("FAIL tag_ret0: got rsp_valid=%0b addr=%h valid=%0b, want 1 %h 0",
               rsp_valid, rsp_addr, valid, tag_of(mk(2, 1, 0, 0, 0)));
    end
    read_data_valid = 1'b0;
    tick();
    n_vec++;
    if (valid !== 1'b1 || command !== mk(2, 1, 16, 16, 0)) begin
      n_err++;
      $display("FAIL tag_17th: got valid=%0b cmd=%h, want 1 %h", valid, command, mk(2, 1, 16, 16, 0));
    end
    for (int i = 1; i < 17; i++) begin
      read_data_valid = 1'b1;
      read_data       = rnd_data();
      tick();
      n_vec++;
      if (rsp_valid !== 1'b1 || rsp_addr !== tag_of(mk(2, 1, i, i, i % 8))) begin
        n_err++;
        $display("FAIL tag_drain[%0d]: got valid=%0b addr=%h, want 1 %h",
                 i, rsp_valid, rsp_addr, tag_of(mk(2, 1, i, i, i % 8)));
      end
    end
    idle_inputs();
    tick();
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 400; cyc++) begin
      in_valid   = ($urandom_range(0, 2) != 0);
      in_command = mk($urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 8191),
                      $urandom_range(0, 1023), $urandom_range(0, 7));
      in_wdata   = rnd_data();
      ba_cmd_pm  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
      read_data_valid = (tq.size() > 0) && ($urandom_range(0, 3) == 0);
      read_data       = rnd_data();
      n_vec++;
      if (in_ready !== (mq.size() < CMD_DEPTH)) begin
        n_err++;
        $display("FAIL rnd_ready@%0d: got %0b, model level %0d", cyc, in_ready, mq.size());
      end
      tick();
      n_vec++;
      if (valid !== e_valid || command !== e_command || write_data !== e_wdata) begin
        n_err++;
        $display("FAIL rnd_issue@%0d: got valid=%0b cmd=%h, want %0b %h",
                 cyc, valid, command, e_valid, e_command);
      end
      n_vec++;
      if (rsp_valid !== e_rsp_valid || (e_rsp_valid && (rsp_data !== e_rsp_data
          || rsp_addr !== e_rsp_addr))) begin
        n_err++;
        $display("FAIL rnd_rsp@%0d: got valid=%0b addr=%h, want %0b %h",
                 cyc, rsp_valid, rsp_addr, e_rsp_valid, e_rsp_addr);
      end
      n_vec++;
      if (level !== 4'(mq.size()) || rsp_underflow !== m_under) begin
        n_err++;
        $display("FAIL rnd_level@%0d: got level=%0d uflow=%0b, want %0d %0b",
                 cyc, level, rsp_underflow, mq.size(), m_under);
      end
    end
    idle_inputs();
  endtask

  task automatic test_flush_underflow();
    do_reset();
    ba_cmd_pm  = 8'hFF;
    in_valid   = 1'b1;
    in_command = mk(1, 1, 3, 3, 5);
    tick();
    idle_inputs();
    tick();
    ba_cmd_pm = 8'h00;
    for (int i = 0; i < 3; i++) begin
      in_valid   = 1'b1;
      in_command = mk(0, 0, i, i, 6);
      in_wdata   = rnd_data();
      tick();
    end
    idle_inputs();
    n_vec++;
    if (level !== 4'd3) begin
      n_err++;
      $display("FAIL flush_pre: got level=%0d, want 3", level);
    end
    power_on_rst_n = 1'b0;
    mq.delete();
    tq.delete();
    m_under = 1'b0;
    #2;
    n_vec++;
    if (level !== 4'd0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL flush_async: got level=%0d in_ready=%0b, want 0 1", level, in_ready);
    end
    @(posedge clk);
    #1;
    power_on_rst_n = 1'b1;
    ba_cmd_pm       = 8'hFF;
    read_data_valid = 1'b1;
    read_data       = rnd_data();
    tick();
    read_data_valid = 1'b0;
    n_vec++;
    if (rsp_valid !== 1'b0 || rsp_underflow !== 1'b1) begin
      n_err++;
      $display("FAIL uflow_set: got rsp_valid=%0b uflow=%0b, want 0 1", rsp_valid, rsp_underflow);
    end
    for (int i = 0; i < 5; i++) tick();
    n_vec++;
    if (rsp_underflow !== 1'b1) begin
      n_err++;
      $display("FAIL uflow_hold: got %0b, want 1", rsp_underflow);
    end
    power_on_rst_n = 1'b0;
    #2;
    n_vec++;
    if (rsp_underflow !== 1'b0) begin
      n_err++;
      $display("FAIL uflow_clear: got %0b, want 0", rsp_underflow);
    end
    @(posedge clk);
    #1;
    power_on_rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_bank_block();
    test_full();
    test_reads_in_order();
    test_tag_full();
    test_random();
    test_flush_underflow();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
